// File: rtl/calc_pkg.sv
// Shared types for the calc_engine accumulator machine: opcodes, FSM states
// and the opcode field width.
package calc_pkg;

  localparam int OP_W = 3;

  typedef enum logic [OP_W-1:0] {
    OP_ADD  = 3'd0,
    OP_SUB  = 3'd1,
    OP_MUL  = 3'd2,
    OP_LOAD = 3'd3,
    OP_CLR  = 3'd4
  } op_e;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_MUL  = 1'b1
  } state_e;

endpackage

// File: rtl/calc_mul_seq.sv
// Iterative shift-add multiplier: one multiplier bit per cycle for WIDTH cycles,
// low WIDTH bits of the product, done_o pulses for one cycle when finished.
module calc_mul_seq #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic             done_o,
  output logic [WIDTH-1:0] product_o
);

  localparam int CW = $clog2(WIDTH);

  logic [WIDTH-1:0] mcand_q;
  logic [WIDTH-1:0] mplier_q;
  logic [WIDTH-1:0] prod_q;
  logic [CW-1:0]    cnt_q;
  logic             busy_q;
  logic             done_q;

  // NOTE: sequential state is written with <= only, so every register samples
  // the values from before the edge and block ordering cannot change behaviour.
  always_ff @(posedge clk) begin
    if (reset) begin
      busy_q <= 1'b0;
      done_q <= 1'b0;
      cnt_q  <= '0;
    end else begin
      done_q <= 1'b0;
      if (start_i) begin
        busy_q <= 1'b1;
        cnt_q  <= '0;
      end else if (busy_q) begin
        cnt_q <= cnt_q + CW'(1);
        if (cnt_q == CW'(WIDTH - 1)) begin
          busy_q <= 1'b0;
          done_q <= 1'b1;
        end
      end
    end
  end

  // NOTE: the datapath is deliberately not reset; it is fully reloaded on
  // start_i and is only observed once done_o has fired.
  always_ff @(posedge clk) begin
    if (start_i) begin
      mcand_q  <= a_i;
      mplier_q <= b_i;
      prod_q   <= '0;
    end else if (busy_q) begin
      prod_q   <= prod_q + (mplier_q[0] ? mcand_q : '0);
      mcand_q  <= mcand_q << 1;
      mplier_q <= mplier_q >> 1;
    end
  end

  assign done_o    = done_q;
  assign product_o = prod_q;

endmodule

// File: rtl/calc_engine.sv
// Accumulator calculator: single-cycle ADD/SUB/LOAD/CLR, optional iterative MUL.
// Define CALC_ENGINE_MUL_EN to build the multiplier; otherwise MUL is illegal.
module calc_engine
  import calc_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int NACC  = 4,
  parameter int IMM_W = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     instr_valid,
  output logic                     instr_ready,
  input  logic [OP_W-1:0]          instr_op,
  input  logic [$clog2(NACC)-1:0]  instr_dst,
  input  logic                     instr_bsel,
  input  logic [IMM_W-1:0]         imm_a,
  input  logic [IMM_W-1:0]         imm_b,
  output logic                     result_valid,
  output logic [WIDTH-1:0]         result,
  output logic                     result_ovf,
  output logic                     result_err,
  input  logic [$clog2(NACC)-1:0]  rd_sel,
  output logic [WIDTH-1:0]         rd_data
);

  localparam int AW = $clog2(NACC);

  function automatic logic [WIDTH-1:0] sext(input logic [IMM_W-1:0] v);
    return {{(WIDTH - IMM_W){v[IMM_W-1]}}, v};
  endfunction

  state_e           state_q;
  logic [WIDTH-1:0] acc_q [NACC];
  logic             result_valid_q;
  logic [WIDTH-1:0] result_q;
  logic             result_ovf_q;
  logic             result_err_q;

  op_e              op;
  logic             accept;
  logic [WIDTH-1:0] a_ext;
  logic [WIDTH-1:0] b_ext;
  logic [WIDTH-1:0] sum;
  logic [WIDTH-1:0] diff;
  logic [WIDTH-1:0] alu_res;
  logic             alu_ovf;
  logic             alu_err;
  logic             alu_wr;
  logic             is_mul;

  assign op          = op_e'(instr_op);
  assign instr_ready = (state_q == S_IDLE);
  assign accept      = instr_valid && instr_ready;
  // B reads the registered file, which already holds the previous write.
  assign a_ext       = sext(imm_a);
  assign b_ext       = instr_bsel ? sext(imm_b) : acc_q[instr_dst];
  assign sum         = a_ext + b_ext;
  assign diff        = a_ext - b_ext;

  // NOTE: every output of this block gets a default before the case so no
  // path leaves a variable unassigned and no latch is inferred.
  always_comb begin
    alu_res = '0;
    alu_ovf = 1'b0;
    alu_err = 1'b0;
    alu_wr  = 1'b0;
    is_mul  = 1'b0;
    unique case (op)
      OP_ADD: begin
        alu_res = sum;
        alu_ovf = (a_ext[WIDTH-1] == b_ext[WIDTH-1]) && (sum[WIDTH-1] != a_ext[WIDTH-1]);
        alu_wr  = 1'b1;
      end
      OP_SUB: begin
        alu_res = diff;
        alu_ovf = (a_ext[WIDTH-1] != b_ext[WIDTH-1]) && (diff[WIDTH-1] != a_ext[WIDTH-1]);
        alu_wr  = 1'b1;
      end
      OP_LOAD: begin
        alu_res = a_ext;
        alu_wr  = 1'b1;
      end
      OP_CLR: begin
        alu_wr = 1'b1;
      end
`ifdef CALC_ENGINE_MUL_EN
      OP_MUL: is_mul = 1'b1;
`endif
      default: alu_err = 1'b1;
    endcase
  end

`ifdef CALC_ENGINE_MUL_EN
  logic [AW-1:0]    mul_dst_q;
  logic             mul_done;
  logic [WIDTH-1:0] mul_product;

  calc_mul_seq #(.WIDTH(WIDTH)) u_mul (
    .clk       (clk),
    .reset     (reset),
    .start_i   (accept && is_mul),
    .a_i       (a_ext),
    .b_i       (b_ext),
    .done_o    (mul_done),
    .product_o (mul_product)
  );
`endif

  // NOTE: the accumulator file is reset because software may read it
  // straight after reset; storage that is always written before use is not.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= S_IDLE;
      result_valid_q <= 1'b0;
      result_q       <= '0;
      result_ovf_q   <= 1'b0;
      result_err_q   <= 1'b0;
      for (int i = 0; i < NACC; i++) acc_q[i] <= '0;
`ifdef CALC_ENGINE_MUL_EN
      mul_dst_q      <= '0;
`endif
    end else begin
      result_valid_q <= 1'b0;
      if (accept && !is_mul) begin
        result_valid_q <= 1'b1;
        result_q       <= alu_res;
        result_ovf_q   <= alu_ovf;
        result_err_q   <= alu_err;
        if (alu_wr) acc_q[instr_dst] <= alu_res;
      end
`ifdef CALC_ENGINE_MUL_EN
      if (accept && is_mul) begin
        state_q   <= S_MUL;
        mul_dst_q <= instr_dst;
      end
      if (state_q == S_MUL && mul_done) begin
        state_q            <= S_IDLE;
        acc_q[mul_dst_q]   <= mul_product;
        result_valid_q     <= 1'b1;
        result_q           <= mul_product;
        result_ovf_q       <= 1'b0;
        result_err_q       <= 1'b0;
      end
`endif
    end
  end

  assign result_valid = result_valid_q;
  assign result       = result_q;
  assign result_ovf   = result_ovf_q;
  assign result_err   = result_err_q;
  assign rd_data      = acc_q[rd_sel];

endmodule

// File: tb/tb_calc_engine.sv
// Self-checking bench for calc_engine: directed scenarios plus random
// instructions compared against an arithmetic reference model.
module tb_calc_engine;

  localparam longint SMAX  = 64'sd2147483647;
  localparam longint SMIN  = -64'sd2147483648;
  localparam longint S18MX = 64'sd131071;
  localparam longint S18MN = -64'sd131072;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        instr_valid = 1'b0;
  logic        instr_ready;
  logic [2:0]  instr_op = '0;
  logic [1:0]  instr_dst = '0;
  logic        instr_bsel = 1'b0;
  logic [15:0] imm_a = '0;
  logic [15:0] imm_b = '0;
  logic        result_valid;
  logic [31:0] result;
  logic        result_ovf;
  logic        result_err;
  logic [1:0]  rd_sel = '0;
  logic [31:0] rd_data;

  // Narrow instance so signed overflow is reachable with 16-bit immediates.
  logic        s_valid = 1'b0;
  logic        s_ready;
  logic [2:0]  s_op = '0;
  logic        s_dst = 1'b0;
  logic        s_bsel = 1'b0;
  logic [15:0] s_imm_a = '0;
  logic [15:0] s_imm_b = '0;
  logic        s_rv;
  logic [17:0] s_res;
  logic        s_ovf;
  logic        s_err;
  logic        s_rd_sel = 1'b0;
  logic [17:0] s_rd_data;

  logic [31:0] ref_acc [4];
  logic [17:0] s_ref = '0;
  int errors = 0;
  int checks = 0;

  calc_engine dut (
    .clk(clk), .reset(reset), .instr_valid(instr_valid), .instr_ready(instr_ready),
    .instr_op(instr_op), .instr_dst(instr_dst), .instr_bsel(instr_bsel),
    .imm_a(imm_a), .imm_b(imm_b), .result_valid(result_valid), .result(result),
    .result_ovf(result_ovf), .result_err(result_err), .rd_sel(rd_sel), .rd_data(rd_data)
  );

  calc_engine #(.WIDTH(18), .NACC(2), .IMM_W(16)) dut_s (
    .clk(clk), .reset(reset), .instr_valid(s_valid), .instr_ready(s_ready),
    .instr_op(s_op), .instr_dst(s_dst), .instr_bsel(s_bsel),
    .imm_a(s_imm_a), .imm_b(s_imm_b), .result_valid(s_rv), .result(s_res),
    .result_ovf(s_ovf), .result_err(s_err), .rd_sel(s_rd_sel), .rd_data(s_rd_data)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation still running at time %0t, required to finish", $time);
    $fatal(1, "watchdog");
  end

  // Issue one instruction, wait for its result and compare against the model.
  task automatic do_op(input logic [2:0] op, input logic [1:0] dst, input logic bsel,
                       input logic [15:0] a, input logic [15:0] b, input string tag);
    logic [31:0] ea, eb, er;
    logic        eo, ee, wr;
    longint      s;
    int          n, hi;
    ea = 32'($signed(a));
    eb = bsel ? 32'($signed(b)) : ref_acc[dst];
    er = '0; ee = 1'b0; wr = 1'b1; s = 0;
    case (op)
      3'd0: begin s = longint'($signed(ea)) + longint'($signed(eb)); er = ea + eb; end
      3'd1: begin s = longint'($signed(ea)) - longint'($signed(eb)); er = ea - eb; end
`ifdef CALC_ENGINE_MUL_EN
      3'd2: er = ea * eb;
`else
      3'd2: begin ee = 1'b1; wr = 1'b0; end
`endif
      3'd3: er = ea;
      3'd4: er = '0;
      default: begin ee = 1'b1; wr = 1'b0; end
    endcase
    eo = (op == 3'd0 || op == 3'd1) && (s > SMAX || s < SMIN);
    checks++;
    if (instr_ready !== 1'b1) begin
      errors++;
      $display("FAIL %s ready_before_issue: got %b expected 1", tag, instr_ready);
    end
    instr_op = op; instr_dst = dst; instr_bsel = bsel; imm_a = a; imm_b = b;
    instr_valid = 1'b1;
    @(posedge clk); #1;
    instr_valid = 1'b0;
    n = 1; hi = 0;
`ifdef CALC_ENGINE_MUL_EN
    if (op == 3'd2) begin
      while (result_valid !== 1'b1 && n < 40) begin
        if (instr_ready !== 1'b0) hi++;
        @(posedge clk); #1;
        n++;
      end
      checks++;
      if (n != 33 || hi != 0 || instr_ready !== 1'b1) begin
        errors++;
        $display("FAIL %s mul_timing: result at cycle %0d, ready-high cycles %0d, ready %b; expected 33, 0, 1",
                 tag, n, hi, instr_ready);
      end
    end
`endif
    checks++;
    if (result_valid !== 1'b1 || result !== er || result_ovf !== eo || result_err !== ee) begin
      errors++;
      $display("FAIL %s result: got v=%b res=%h ovf=%b err=%b expected v=1 res=%h ovf=%b err=%b",
               tag, result_valid, result, result_ovf, result_err, er, eo, ee);
    end
    if (wr) ref_acc[dst] = er;
    rd_sel = dst; #1;
    checks++;
    if (rd_data !== ref_acc[dst]) begin
      errors++;
      $display("FAIL %s rd_data[%0d]: got %h expected %h", tag, dst, rd_data, ref_acc[dst]);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    instr_op = 3'd3; instr_dst = 2'd0; imm_a = 16'h1234; instr_valid = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0; instr_valid = 1'b0;
    checks++;
    if (instr_ready !== 1'b1 || result_valid !== 1'b0 || result !== 32'h0 ||
        result_ovf !== 1'b0 || result_err !== 1'b0) begin
      errors++;
      $display("FAIL reset_outputs: got rdy=%b v=%b res=%h ovf=%b err=%b expected 1 0 0 0 0",
               instr_ready, result_valid, result, result_ovf, result_err);
    end
    for (int i = 0; i < 4; i++) begin
      rd_sel = 2'(i); #1;
      ref_acc[i] = '0;
      checks++;
      if (rd_data !== 32'h0) begin
        errors++;
        $display("FAIL reset_acc[%0d]: got %h expected 0", i, rd_data);
      end
    end
    @(posedge clk); #1;
    checks++;
    if (result_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_no_accept: got result_valid %b expected 0", result_valid);
    end
  endtask

  task automatic test_load_add_sub();
    do_op(3'd3, 2'd1, 1'b0, 16'd5, 16'd0, "load5");
    do_op(3'd0, 2'd1, 1'b0, 16'd3, 16'd0, "add_fwd");
    do_op(3'd1, 2'd1, 1'b1, 16'd0, 16'd1, "sub_neg");
    rd_sel = 2'd1; #1;
    checks++;
    if (rd_data !== 32'hFFFF_FFFF) begin
      errors++;
      $display("FAIL sub_literal: got %h expected ffffffff", rd_data);
    end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 8; i++)
      do_op(3'(i % 2), 2'd3, 1'b0, 16'($urandom()), 16'd0, "b2b_hazard");
    do_op(3'd4, 2'd3, 1'b0, 16'hABCD, 16'd0, "clr");
  endtask

  task automatic test_illegal();
    do_op(3'd6, 2'd1, 1'b1, 16'h1111, 16'h2222, "illegal6");
    do_op(3'd5, 2'd2, 1'b0, 16'h3333, 16'h0, "illegal5");
    do_op(3'd7, 2'd3, 1'b1, 16'h4444, 16'h5, "illegal7");
    for (int i = 0; i < 4; i++) begin
      rd_sel = 2'(i); #1;
      checks++;
      if (rd_data !== ref_acc[i]) begin
        errors++;
        $display("FAIL illegal_nowrite[%0d]: got %h expected %h", i, rd_data, ref_acc[i]);
      end
    end
  endtask

  task automatic test_mul();
    do_op(3'd2, 2'd2, 1'b1, 16'hFFFD, 16'd7, "mul_m3x7");
    do_op(3'd2, 2'd0, 1'b0, 16'd9, 16'd0, "mul_acc");
  endtask

  // 18-bit instance, accumulator 0, B always the accumulator.
  task automatic small_op(input logic [2:0] op, input logic [15:0] a, input string tag);
    longint cur, sa, s;
    logic   eo;
    logic [17:0] er;
    cur = longint'(s_ref);
    if (cur >= 131072) cur -= 262144;
    sa = longint'($signed(a));
    case (op)
      3'd0:    s = sa + cur;
      3'd1:    s = sa - cur;
      default: s = sa;
    endcase
    eo = (op != 3'd3) && (s > S18MX || s < S18MN);
    er = 18'(s);
    s_op = op; s_dst = 1'b0; s_bsel = 1'b0; s_imm_a = a; s_valid = 1'b1;
    @(posedge clk); #1;
    s_valid = 1'b0;
    checks++;
    if (s_rv !== 1'b1 || s_res !== er || s_ovf !== eo || s_err !== 1'b0) begin
      errors++;
      $display("FAIL %s narrow: got v=%b res=%h ovf=%b err=%b expected v=1 res=%h ovf=%b err=0",
               tag, s_rv, s_res, s_ovf, s_err, er, eo);
    end
    s_ref = er;
    checks++;
    if (s_rd_data !== s_ref) begin
      errors++;
      $display("FAIL %s narrow_rd: got %h expected %h", tag, s_rd_data, s_ref);
    end
  endtask

  task automatic test_overflow();
    small_op(3'd3, 16'h7FFF, "ov_load_max");
    for (int i = 0; i < 4; i++) small_op(3'd0, 16'h7FFF, "ov_add_pos");
    small_op(3'd1, 16'h0000, "ov_sub_small");
    small_op(3'd3, 16'h8000, "ov_load_min");
    for (int i = 0; i < 3; i++) small_op(3'd0, 16'h8000, "ov_add_neg");
    small_op(3'd1, 16'h0000, "ov_sub_cross");
    small_op(3'd3, 16'h8000, "ov_load_min2");
    for (int i = 0; i < 4; i++) small_op(3'd0, 16'h8000, "ov_add_neg_cross");
  endtask

  task automatic test_random();
    for (int i = 0; i < 40; i++) begin
      logic [2:0] op;
      op = 3'($urandom_range(0, 7));
      do_op(op, 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
            16'($urandom()), 16'($urandom()), "random");
    end
  endtask

  task automatic test_mul_abort();
    int n_rv;
    do_op(3'd3, 2'd3, 1'b0, 16'd9, 16'd0, "abort_pre");
`ifdef CALC_ENGINE_MUL_EN
    instr_op = 3'd2; instr_dst = 2'd3; instr_bsel = 1'b1; imm_a = 16'd5; imm_b = 16'd6;
    instr_valid = 1'b1;
    @(posedge clk); #1;
    instr_valid = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    checks++;
    if (instr_ready !== 1'b0) begin
      errors++;
      $display("FAIL abort_busy: got ready %b expected 0", instr_ready);
    end
`endif
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    for (int i = 0; i < 4; i++) ref_acc[i] = '0;
    s_ref = '0;
    checks++;
    if (instr_ready !== 1'b1) begin
      errors++;
      $display("FAIL abort_ready: got %b expected 1", instr_ready);
    end
    n_rv = 0;
    repeat (40) begin
      if (result_valid === 1'b1) n_rv++;
      @(posedge clk); #1;
    end
    checks++;
    if (n_rv != 0) begin
      errors++;
      $display("FAIL abort_no_result: got %0d result pulses expected 0", n_rv);
    end
    rd_sel = 2'd3; #1;
    checks++;
    if (rd_data !== 32'h0) begin
      errors++;
      $display("FAIL abort_acc: got %h expected 0", rd_data);
    end
  endtask

  initial begin
    for (int i = 0; i < 4; i++) ref_acc[i] = '0;
    test_reset();
    test_load_add_sub();
    test_back_to_back();
    test_illegal();
    test_mul();
    test_overflow();
    test_random();
    test_mul_abort();
    do_op(3'd3, 2'd0, 1'b0, 16'h0042, 16'd0, "post_reset_load");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
